// File: rtl/vdiff_ramp_pkg.sv
// vdiff_ramp_pkg: channel state enum, saturation widths and clamp helper
package vdiff_ramp_pkg;
  typedef enum logic {SETTLED, RAMP} state_t;
  localparam int MAX_W = 32;
  localparam int SAT_W = MAX_W + 2;
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x, input int w);
    logic signed [SAT_W-1:0] hi;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    return x > hi ? hi : x < -hi - SAT_W'(1) ? -hi - SAT_W'(1) : x;
  endfunction
endpackage

// File: rtl/vdiff_ramp_drive_if.sv
// vdiff_ramp_drive_if: target word valid/ready handshake
interface vdiff_ramp_drive_if #(
  parameter int N_CH = 4,
  parameter int W    = 16
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic                in_valid;
  logic                in_ready;
  logic [CW-1:0]       in_ch;
  logic signed [W-1:0] in_diff;
  logic signed [W-1:0] in_cm;
  modport master(output in_valid, in_ch, in_diff, in_cm, input in_ready);
  modport slave(input in_valid, in_ch, in_diff, in_cm, output in_ready);
endinterface

// File: rtl/vdiff_ramp_ch.sv
// vdiff_ramp_ch: one channel's diff/cm ramp state machine and registered vinp/vinn stage
module vdiff_ramp_ch
  import vdiff_ramp_pkg::*;
#(
  parameter int W = 16,
  parameter int F = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld,
  input  logic signed [W-1:0] ld_diff,
  input  logic signed [W-1:0] ld_cm,
  input  logic signed [W-1:0] scale_d,
  input  logic signed [W-1:0] scale_c,
  input  logic [W-2:0]        ramp_step,
  output logic signed [W-1:0] vinp,
  output logic signed [W-1:0] vinn,
  output logic                settled,
  output logic                sat
);
  state_t                state, state_nxt;
  logic signed [W-1:0]   cur_d, cur_c, tgt_d, tgt_c, nxt_d, nxt_c;
  logic signed [2*W-1:0] pd, pc;
  logic signed [W+1:0]   td, tc, sp, sn;
  logic signed [W-1:0]   op, on;
  logic                  sat_nxt;

  function automatic logic signed [W-1:0] step_to(input logic signed [W-1:0] c, t, input logic [W-2:0] s);
    logic signed [W:0] d;
    logic [W:0]        a;
    d = (W+1)'(t) - (W+1)'(c);
    a = d[W] ? -d : d;
    return (s == '0 || a <= (W+1)'(s)) ? t : d[W] ? c - W'(s) : c + W'(s);
  endfunction

  always_comb begin
    nxt_d     = state == RAMP ? step_to(cur_d, tgt_d, ramp_step) : cur_d;
    nxt_c     = state == RAMP ? step_to(cur_c, tgt_c, ramp_step) : cur_c;
    state_nxt = ld ? ((ld_diff == nxt_d && ld_cm == nxt_c) ? SETTLED : RAMP)
              : (state == RAMP && nxt_d == tgt_d && nxt_c == tgt_c) ? SETTLED : state;
  end

  always_comb begin
    pd      = (2*W)'(scale_d) * (2*W)'(cur_d);
    pc      = (2*W)'(scale_c) * (2*W)'(cur_c);
    td      = (W+2)'(pd >>> (F + 1));
    tc      = (W+2)'(pc >>> F);
    sp      = tc + td;
    sn      = tc - td;
    op      = W'(saturate(SAT_W'(sp), W));
    on      = W'(saturate(SAT_W'(sn), W));
    sat_nxt = sp != (W+2)'(op) || sn != (W+2)'(on);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLED;
      cur_d <= '0;
      cur_c <= '0;
      tgt_d <= '0;
      tgt_c <= '0;
      vinp  <= '0;
      vinn  <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      cur_d <= nxt_d;
      cur_c <= nxt_c;
      tgt_d <= ld ? ld_diff : tgt_d;
      tgt_c <= ld ? ld_cm : tgt_c;
      vinp  <= op;
      vinn  <= on;
      sat   <= sat_nxt;
    end
  end

  assign settled = state == SETTLED;
endmodule

// File: rtl/vdiff_ramp_drive.sv
// vdiff_ramp_drive: target handshake and demux onto N_CH ramped differential channels
module vdiff_ramp_drive
  import vdiff_ramp_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 16,
  parameter int F        = 12,
  parameter int RETARGET = 1
) (
  input  logic                clk,
  input  logic                rst,
  vdiff_ramp_drive_if.slave   bus,
  input  logic signed [W-1:0] scale_d,
  input  logic signed [W-1:0] scale_c,
  input  logic [W-2:0]        ramp_step,
  output logic [N_CH*W-1:0]   vinp,
  output logic [N_CH*W-1:0]   vinn,
  output logic [N_CH-1:0]     settled,
  output logic [N_CH-1:0]     sat
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic acc;

  assign bus.in_ready = !rst && (RETARGET != 0 || settled[bus.in_ch]);
  assign acc          = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    vdiff_ramp_ch #(.W(W), .F(F)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ld       (acc && bus.in_ch == CW'(k)),
      .ld_diff  (bus.in_diff),
      .ld_cm    (bus.in_cm),
      .scale_d  (scale_d),
      .scale_c  (scale_c),
      .ramp_step(ramp_step),
      .vinp     (vinp[k*W +: W]),
      .vinn     (vinn[k*W +: W]),
      .settled  (settled[k]),
      .sat      (sat[k])
    );
  end
endmodule

// File: doc/vdiff_ramp_drive.md
VDIFF_RAMP_DRIVE -- requirements
Module: vdiff_ramp_drive

Interface
REQ-001 Parameter N_CH, default 4: number of independent differential channels (1..16).
REQ-002 Parameter W, default 16: signed two's-complement data width of all voltage words.
REQ-003 Parameter F, default 12: fractional bits; value 1.0 = 2^F.
REQ-004 Parameter RETARGET, default 1: 1 = a new target may interrupt a ramp; 0 = the addressed channel blocks until settled.
REQ-005 clk  in  1  single clock, rising-edge; one clock, reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  target word valid.
REQ-008 in_ready  out  1  target word accepted when in_valid & in_ready.
REQ-009 in_ch  in  clog2(N_CH)  channel index of target.
REQ-010 in_diff  in  W  target differential voltage (vinp-vinn), signed QW.F.
REQ-011 in_cm  in  W  target common-mode voltage (vinp+vinn)/2, signed QW.F.
REQ-012 scale_d, scale_c  in  W each  signed QW.F gains, shared by all channels, sampled every cycle.
REQ-013 ramp_step  in  W-1  unsigned max change per cycle of diff and cm; 0 = immediate load.
REQ-014 vinp, vinn  out  N_CH*W  per-channel single-ended outputs, channel k at bits [k*W +: W].
REQ-015 settled  out  N_CH  channel current value equals target.
REQ-016 sat  out  N_CH  channel vinp or vinn saturated this cycle.

Function
REQ-017 Per-channel state machine SHALL have states SETTLED and RAMP; reset state SETTLED.
REQ-018 An accepted word SHALL load target_diff/target_cm of channel in_ch on that edge and move it to RAMP (or stay SETTLED if targets equal current values).
REQ-019 in_ready SHALL be 0 during rst; otherwise 1 if RETARGET=1, else 1 only when channel in_ch is SETTLED.
REQ-020 In RAMP, each cycle cur_x SHALL move toward target_x by ramp_step; if |target_x-cur_x| <= ramp_step, cur_x = target_x (x = diff, cm, independently).
REQ-021 Channel SHALL return to SETTLED on the edge where both cur_diff and cur_cm equal target; ramp_step=0 SHALL set cur = target on the edge after acceptance.
REQ-022 Retarget during RAMP (RETARGET=1) SHALL continue from the present cur values toward the new target, with no output discontinuity.
REQ-023 vinp = sat(((scale_c*cur_cm) >>> F) + ((scale_d*cur_diff) >>> (F+1))); vinn identical with the diff term subtracted.
REQ-024 Products SHALL be 2W bits; shifts arithmetic (floor); sum in W+2 bits; saturation clamps to [-2^(W-1), 2^(W-1)-1].
REQ-025 vinp/vinn/sat SHALL be registered, reflecting cur values of the previous edge (latency: acceptance -> first output change = 2 cycles).
REQ-026 Difference |target-cur| SHALL be computed in W+1 bits; no wrap-around for full-scale opposite-sign targets.
REQ-027 Only the channel addressed by an accepted word SHALL change target; other channels unaffected.

Reset
REQ-028 On rst, all cur/target registers SHALL clear to 0, states to SETTLED, vinp/vinn to 0, settled to all-ones, sat to 0.
REQ-029 rst asserted mid-ramp SHALL abort the ramp on that edge; in_valid during rst SHALL be ignored.

Structure
REQ-030 Package vdiff_ramp_pkg SHALL hold the state enum, saturation width constants and the saturate function.
REQ-031 Per-channel ramp and output arithmetic SHALL be sub-module vdiff_ramp_ch, generated N_CH times; top holds handshake and demux only.

Verification (W=16, F=12, scales 1.0=4096)
REQ-032 Reset, then load ch0 diff=0.5(2048) cm=0.25(1024), step=0 -> after 2 cycles vinp=2048, vinn=0, settled[0]=1.
REQ-033 ch1 diff 0->1024, step=256 -> settled[1]=0 for 4 edges, vinp rises by 128/cycle to 512, vinn falls to -512, then settled.
REQ-034 RETARGET=0, ch2 ramping, in_valid to ch2 -> in_ready=0 until settled[2]=1; word to ch3 same cycle accepted.
REQ-035 cm=32767, diff=32767, scale_c=scale_d=4096 -> vinp=32767, sat=1; vinn=16384, no wrap.
REQ-036 Retarget ch0 mid-ramp from +4096 toward -4096 -> output reverses monotonically from present value, no jump.
REQ-037 rst asserted mid-ramp -> next edge all outputs 0, settled all-ones, in_ready=0.
